lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have no parameters; data and address widths are fixed at 32 bits.
REQ-002 SHALL have port clk, input, 1 bit, the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit, core requests a load/store, held stable until done.
REQ-005 SHALL have port req_write, input, 1 bit, 1=store, 0=load.
REQ-006 SHALL have port req_funct3, input, 3 bits, RV32I size/sign code.
REQ-007 SHALL have port req_addr, input, 32 bits, effective address from the ALU result.
REQ-008 SHALL have port req_wdata, input, 32 bits, store data (rs2).
REQ-009 SHALL have port busy, output, 1 bit, core stall.
REQ-010 SHALL have port done, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32 bits, extended load result.
REQ-012 SHALL have port misaligned, output, 1 bit, alignment fault flag, valid with done.
REQ-013 SHALL have mem_valid (output, 1), mem_ready (input, 1), mem_we (output, 1), mem_addr (output, 32), mem_be (output, 4), mem_wdata (output, 32), mem_rvalid (input, 1) and mem_rdata (input, 32) as the data-memory port.

Function
REQ-014 SHALL implement an FSM with states IDLE, REQ, WAIT and DONE.
REQ-015 IDLE with req_valid=1 SHALL register all req_* fields and go to REQ; an invalid funct3 (011, 110 or 111) SHALL go straight to DONE with no memory access.
REQ-016 In REQ, mem_valid SHALL be 1 and mem_addr/we/be/wdata SHALL be stable until mem_ready=1.
REQ-017 A REQ handshake on a store SHALL go to DONE; on a load it SHALL go to WAIT.
REQ-018 WAIT SHALL stay until mem_rvalid=1, then capture the extended load data into rdata and go to DONE; mem_rvalid outside WAIT SHALL be ignored.
REQ-019 DONE SHALL assert done for exactly one cycle and then go to IDLE; req_valid SHALL be ignored in DONE.
REQ-020 busy SHALL be (state==IDLE && req_valid) || state==REQ || state==WAIT, driven combinationally.
REQ-021 Best-case latency from accept SHALL be: store, done 2 cycles after the accept edge; load, done 3 cycles after it.
REQ-022 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-023 Byte stores (000) SHALL use mem_be=1<<addr[1:0] with the byte replicated on all 4 lanes.
REQ-024 Halfword stores (001) SHALL use mem_be=4'b0011 or 4'b1100 selected by addr[1], with the halfword replicated on both lanes.
REQ-025 Word stores (010) SHALL use mem_be=4'b1111; mem_be SHALL be 4'b1111 for all loads.
REQ-026 Loads SHALL select the lane by addr[1:0] (byte) or addr[1] (half); LB/LH SHALL sign-extend, LBU/LHU SHALL zero-extend, and LW SHALL pass through.
REQ-027 rdata SHALL hold its value until the next load completes; stores SHALL leave rdata unchanged.

Reset
REQ-028 rst_n=0 at any clock edge SHALL force IDLE, mem_valid=0, done=0, rdata=0 and misaligned=0, abandoning any transaction in flight.
REQ-029 A mem_rvalid arriving after reset SHALL be ignored.

Configuration
REQ-030 With MISALIGN_TRAP_EN defined, halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 SHALL skip memory, go to DONE, set misaligned=1 with done, and leave rdata unchanged.
REQ-031 Without MISALIGN_TRAP_EN, misaligned SHALL be tied to 0 and the offending low address bits SHALL be ignored per REQ-022 to REQ-026.

Structure
REQ-032 Package lsu_pkg SHALL hold the funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum.
REQ-033 Lane steering and extension SHALL be a combinational sub-module lsu_align instantiated once.

Verification
REQ-034 The bench SHALL check: SB with addr=0x1003 and wdata=0xAB, mem_ready=1 -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, done 2 cycles after accept.
REQ-035 The bench SHALL check: LH at addr=0x2002 with mem_rdata=0x8001_1234 -> rdata=0xFFFF8001; LHU at the same address -> rdata=0x00008001.
REQ-036 The bench SHALL check: LW with mem_ready low for 3 cycles and rvalid 2 cycles later -> mem_valid held 4 cycles, stable outputs, busy high throughout, single done pulse.
REQ-037 The bench SHALL check: rst_n=0 during WAIT, then a late rvalid -> IDLE, no done, rdata=0.
REQ-038 The bench SHALL check: with MISALIGN_TRAP_EN, LW at addr=0x3001 -> mem_valid never asserted, done and misaligned=1 in the same cycle; without the macro -> normal access at 0x3000.
REQ-039 The bench SHALL check: funct3=011 -> no memory access, done pulse, rdata unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and small decode helpers used by the top and the lane aligner.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  function automatic logic f3_invalid(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  // Natural alignment violation for half/word; bytes can never fault.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return !f3_invalid(f3) &&
           (((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00)));
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory port of the LSU: request handshake plus read-data return.
interface lsu_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enables/replication and load
// lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mrdata,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic [3:0][7:0] rl;
  logic [3:0][7:0] wl;
  logic [7:0]      rb;
  logic [15:0]     rh;

  assign rl = mrdata;
  assign rb = rl[addr_lo];
  assign rh = addr_lo[1] ? mrdata[31:16] : mrdata[15:0];

  always_comb begin
    rext = mrdata;
    case (funct3)
      LB:      rext = {{24{rb[7]}}, rb};
      LH:      rext = {{16{rh[15]}}, rh};
      LW:      rext = mrdata;
      LBU:     rext = {24'b0, rb};
      LHU:     rext = {16'b0, rh};
      default: rext = mrdata;
    endcase
  end

  // Small stores are replicated so memory can pick any lane by byte-enable.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign wl[i] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                   (funct3[1:0] == 2'b01) ? wdata[8*(i%2) +: 8] :
                                            wdata[8*i +: 8];
  end
  assign wlane = wl;

  always_comb begin
    be = 4'b1111;
    if (write) begin
      case (funct3[1:0])
        2'b00:   be = 4'b0001 << addr_lo;
        2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: single outstanding access, IDLE/REQ/WAIT/DONE FSM.
// Optional MISALIGN_TRAP_EN makes misaligned half/word accesses fault.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  lsu_if.master       mem
);

  state_t      state, nxt;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] rdata_q;
  logic [31:0] rext;
  logic        req_mis;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n)
      mis_q <= 1'b0;
    else if (state == IDLE && req_valid)
      mis_q <= req_mis;
  end

  assign misaligned = mis_q && done;
`else
  assign req_mis    = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      r_write <= 1'b0;
      r_f3    <= 3'b0;
      r_addr  <= 32'b0;
      r_wdata <= 32'b0;
      rdata_q <= 32'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        r_write <= req_write;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // Return data only counts while a load is actually waiting for it.
      if (state == WAIT && mem.mem_rvalid)
        rdata_q <= rext;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (req_valid)
              nxt = (f3_invalid(req_funct3) || req_mis) ? DONE : REQ;
      REQ:  if (mem.mem_ready)
              nxt = r_write ? DONE : WAIT;
      WAIT: if (mem.mem_rvalid)
              nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3  (r_f3),
    .write   (r_write),
    .addr_lo (r_addr[1:0]),
    .wdata   (r_wdata),
    .mrdata  (mem.mem_rdata),
    .be      (mem.mem_be),
    .wlane   (mem.mem_wdata),
    .rext    (rext)
  );

  assign mem.mem_valid = (state == REQ);
  assign mem.mem_we    = r_write;
  assign mem.mem_addr  = {r_addr[31:2], 2'b00};

  assign busy  = (state == IDLE && req_valid) || state == REQ || state == WAIT;
  assign done  = (state == DONE);
  assign rdata = rdata_q;

endmodule
